work_rx: RTL and testbench

WORK_RX -- requirements
Module: work_rx

---
 rtl/work_rx.sv | 132 +++++++++++++
 tb/tb_work_rx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/work_rx.sv
// Host-link work receiver: frames sync + 108 payload bytes + CRC-12, and hands
// CRC-verified header/target to the miner. Partial or corrupt frames never touch mining work.
module work_rx #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic [607:0] header,
    output logic [255:0] target,
    output logic         work_valid,
    output logic         crc_err,
    output logic [7:0]   err_count
);
    // rx_valid/rx_ready: a byte transfers on any rising edge where both are high;
    // rx_data is only sampled on such an edge.

    typedef enum logic [2:0] {IDLE, PAYLOAD, CRC_HI, CRC_LO, CHECK} state_t;

    localparam int              IW       = $clog2(TIMEOUT + 1);
    localparam logic [IW-1:0]   IDLE_MAX = IW'(TIMEOUT - 1);
    localparam logic [6:0]      LAST_IDX = 7'd107;

    state_t         state, state_nx;
    logic           ready_en;
    logic           accept;
    logic           timeout;
    logic           crc_match;
    logic           err_inc;
    logic [6:0]     cnt;
    logic [11:0]    crc;
    logic [7:0]     crc_hi_q;
    logic [7:0]     crc_lo_q;
    logic [IW-1:0]  idle_cnt;
    logic [863:0]   shadow;

    // CRC-12 (poly 0x80F), one byte MSB first.
    function automatic logic [11:0] crc12_byte(input logic [11:0] c, input logic [7:0] d);
        logic [11:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[11] ^ d[i]) r = {r[10:0], 1'b0} ^ 12'h80F;
            else              r = {r[10:0], 1'b0};
        end
        return r;
    endfunction

    assign rx_ready  = ready_en && (state != CHECK);
    assign accept    = rx_valid && rx_ready;
    assign crc_match = (crc_hi_q[7:4] == 4'h0) && ({crc_hi_q[3:0], crc_lo_q} == crc);
    assign err_inc   = timeout || ((state == CHECK) && !crc_match);

    always_comb begin
        state_nx = state;
        timeout  = 1'b0;
        case (state)
            IDLE:    if (accept && rx_data == 8'hA5) state_nx = PAYLOAD;
            PAYLOAD: if (accept && cnt == LAST_IDX)  state_nx = CRC_HI;
            CRC_HI:  if (accept)                     state_nx = CRC_LO;
            CRC_LO:  if (accept)                     state_nx = CHECK;
            CHECK:                                   state_nx = IDLE;
            default:                                 state_nx = IDLE;
        endcase
        // A silent link mid-frame abandons the frame.
        if ((state == PAYLOAD || state == CRC_HI || state == CRC_LO) &&
            !accept && idle_cnt == IDLE_MAX) begin
            timeout  = 1'b1;
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready_en <= 1'b0;
        end else begin
            state    <= state_nx;
            ready_en <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            crc        <= '0;
            crc_hi_q   <= '0;
            crc_lo_q   <= '0;
            idle_cnt   <= '0;
            shadow     <= '0;
            header     <= '0;
            target     <= '0;
            work_valid <= 1'b0;
            crc_err    <= 1'b0;
            err_count  <= '0;
        end else begin
            work_valid <= 1'b0;
            crc_err    <= 1'b0;

            if (state == IDLE || state == CHECK || accept || timeout) idle_cnt <= '0;
            else                                                       idle_cnt <= idle_cnt + 1'b1;

            case (state)
                IDLE: if (accept && rx_data == 8'hA5) begin
                    cnt <= '0;
                    crc <= '0;
                end
                PAYLOAD: if (accept) begin
                    shadow[{cnt, 3'b000} +: 8] <= rx_data;
                    crc                        <= crc12_byte(crc, rx_data);
                    cnt                        <= cnt + 1'b1;
                end
                CRC_HI: if (accept) crc_hi_q <= rx_data;
                CRC_LO: if (accept) crc_lo_q <= rx_data;
                CHECK: begin
                    if (crc_match) begin
                        header     <= shadow[607:0];
                        target     <= shadow[863:608];
                        work_valid <= 1'b1;
                    end else begin
                        crc_err    <= 1'b1;
                    end
                end
                default: ;
            endcase

            if (err_inc && err_count != 8'hFF) err_count <= err_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_work_rx.sv
// Self-checking bench for work_rx: drives framed work over the byte link and
// scoreboards every work_valid pulse against the frames expected to verify.
module tb_work_rx;
  localparam int TIMEOUT = 32;

  logic         clk;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [607:0] header;
  logic [255:0] target;
  logic         work_valid;
  logic         crc_err;
  logic [7:0]   err_count;

  work_rx #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .header     (header),
    .target     (target),
    .work_valid (work_valid),
    .crc_err    (crc_err),
    .err_count  (err_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  logic [863:0] exp_q[$];
  logic [863:0] exp_work = '0;
  logic [7:0]   exp_err  = '0;
  logic [7:0]   pl[108];

  task automatic check(input string tag, input logic [863:0] got, input logic [863:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [863:0] pack_payload();
    logic [863:0] v;
    for (int k = 0; k < 108; k++) v[8*k +: 8] = pl[k];
    return v;
  endfunction

  // Reference CRC: long division of payload * x^12 by the generator.
  function automatic logic [11:0] model_crc(input logic [863:0] v);
    logic [11:0] r;
    logic        top;
    r = '0;
    for (int i = 0; i < 864 + 12; i++) begin
      top = r[11];
      r   = {r[10:0], (i < 864) ? v[8*(i/8) + 7 - (i%8)] : 1'b0};
      if (top) r = r ^ 12'h80F;
    end
    return r;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  // driver: waits gap idle cycles, then offers b until accepted
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    int   t;
    rx_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    t = 0;
    forever begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      t++;
      if (t > 50) begin
        check("accept_timeout", 1'b0, 1'b1);
        break;
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input int max_gap, input int stall_idx,
                            input logic [11:0] crc_flip, input logic [3:0] hi_top);
    logic [863:0] v;
    logic [11:0]  c;
    logic         good;
    v    = pack_payload();
    c    = model_crc(v) ^ crc_flip;
    good = (crc_flip == 12'h000) && (hi_top == 4'h0);
    if (good) exp_q.push_back(v);
    send_byte(8'hA5, $urandom_range(0, max_gap));
    for (int k = 0; k < 108; k++)
      send_byte(pl[k], (k == stall_idx) ? TIMEOUT - 1 : $urandom_range(0, max_gap));
    send_byte({hi_top, c[11:8]}, $urandom_range(0, max_gap));
    send_byte(c[7:0], $urandom_range(0, max_gap));
    @(negedge clk);
    check("early_pulse", work_valid | crc_err, 1'b0);
    @(posedge clk);
    @(negedge clk);
    if (good) exp_work = v;
    else      exp_err  = sat_inc(exp_err);
    check("work_valid", work_valid, good);
    check("crc_err", crc_err, !good);
    check("err_count", err_count, exp_err);
    check("work_out", {target, header}, exp_work);
    @(posedge clk);
    #1;
  endtask

  task automatic send_partial(input int n);
    send_byte(8'hA5, 0);
    for (int k = 0; k < n; k++) send_byte(pl[k], 0);
  endtask

  task automatic fill_random();
    for (int k = 0; k < 108; k++) pl[k] = 8'($urandom_range(0, 255));
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && work_valid && crc_err) check("pulse_exclusive", 1'b1, 1'b0);
    if (rst_n && work_valid) begin
      if (exp_q.size() == 0) check("unexpected_work", 1'b1, 1'b0);
      else check("sb_work", {target, header}, exp_q.pop_front());
    end
  end

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", rx_ready, 1'b0);
    check("rst_work", {target, header}, '0);
    check("rst_wv", work_valid, 1'b0);
    check("rst_ce", crc_err, 1'b0);
    check("rst_errcnt", err_count, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", rx_ready, 1'b0);
    @(posedge clk);
    #1;
    check("ready_after_edge", rx_ready, 1'b1);

    // all-zero frame
    for (int k = 0; k < 108; k++) pl[k] = 8'h00;
    send_frame(0, -1, 12'h000, 4'h0);

    // single set bit in byte 0, good then corrupted CRC
    pl[0] = 8'h01;
    send_frame(0, -1, 12'h000, 4'h0);
    check("hdr_lsb", header[7:0], 8'h01);
    send_frame(0, -1, 12'h001, 4'h0);

    // junk before sync, random gaps, sync byte embedded in payload
    send_byte(8'h00, 0);
    send_byte(8'h13, 2);
    fill_random();
    pl[10] = 8'hA5;
    pl[11] = 8'hA5;
    send_frame(5, -1, 12'h000, 4'h0);

    // nonzero upper nibble of CRC high byte is a mismatch
    fill_random();
    send_frame(1, -1, 12'h000, 4'h8);

    // a stall one cycle short of the timeout is tolerated
    fill_random();
    send_frame(0, 40, 12'h000, 4'h0);

    // timeout mid-payload
    fill_random();
    send_partial(50);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    check("to_not_yet", err_count, exp_err);
    @(posedge clk);
    #1;
    exp_err = sat_inc(exp_err);
    check("to_errcnt", err_count, exp_err);
    check("to_no_crc_err", crc_err, 1'b0);
    fill_random();
    send_frame(2, -1, 12'h000, 4'h0);

    // saturate the error counter
    for (int n = 0; n < 300; n++) begin
      fill_random();
      send_frame(0, -1, 12'(n + 1), 4'h0);
    end
    check("sat_errcnt", err_count, 8'hFF);

    // reset mid-frame
    fill_random();
    send_partial(60);
    rst_n = 1'b0;
    #1;
    exp_work = '0;
    exp_err  = '0;
    check("mid_rst_work", {target, header}, '0);
    check("mid_rst_errcnt", err_count, 8'h00);
    check("mid_rst_ready", rx_ready, 1'b0);
    check("mid_rst_pulses", work_valid | crc_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill_random();
    send_frame(3, -1, 12'h000, 4'h0);

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end
endmodule
